// File: rtl/time_set_ctrl.sv
// Run/set sequencer for the alarm-clock timekeeping chain: cascades the 1 Hz tick in RUN and
// steers increment presses (with auto-repeat) to the minutes or hours counter in SET.
module time_set_ctrl #(
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_PER  = 10_000_000,
    parameter int unsigned TIMEOUT_TCK = 10
) (
    input  logic       tsc_clk,
    input  logic       tsc_rst,
    input  logic       tsc_tick,
    input  logic       tsc_mode_btn,
    input  logic       tsc_inc_btn,
    input  logic       tsc_sec_wrap,
    input  logic       tsc_min_wrap,
    output logic       tsc_sec_en,
    output logic       tsc_min_en,
    output logic       tsc_hr_en,
    output logic       tsc_sec_clr,
    output logic [1:0] tsc_state,
    output logic       tsc_blink
);

    localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
    localparam int unsigned PW = $clog2(REPEAT_PER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_TCK + 1);

    localparam logic [RW-1:0] RepDly   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RepDlyM1 = RW'(REPEAT_DLY - 1);
    localparam logic [PW-1:0] RepPerM1 = PW'(REPEAT_PER - 1);
    localparam logic [TW-1:0] ToutM1   = TW'(TIMEOUT_TCK - 1);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetMin = 2'b01,
        StSetHr  = 2'b10,
        StBad    = 2'b11
    } state_e;

    state_e        state_q;
    logic          mode_q;
    logic          inc_q;
    logic [RW-1:0] rep_cnt_q;
    logic [PW-1:0] per_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          sec_en_q;
    logic          min_en_q;
    logic          hr_en_q;
    logic          sec_clr_q;
    logic          blink_q;

    logic mode_rise;
    logic inc_rise;
    logic inc_hold;
    logic rep_fire;

    assign mode_rise = tsc_mode_btn & ~mode_q;
    assign inc_rise  = tsc_inc_btn & ~inc_q;
    assign inc_hold  = tsc_inc_btn & inc_q;

    // rep_cnt_q lags the hold length by one cycle, then saturates and hands over to per_cnt_q.
    assign rep_fire = inc_hold &&
                      ((rep_cnt_q == RepDlyM1) ||
                       ((rep_cnt_q == RepDly) && (per_cnt_q == RepPerM1)));

    always_ff @(posedge tsc_clk or posedge tsc_rst) begin
        if (tsc_rst) begin
            state_q   <= StRun;
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
            rep_cnt_q <= '0;
            per_cnt_q <= '0;
            to_cnt_q  <= '0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hr_en_q   <= 1'b0;
            sec_clr_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            mode_q    <= tsc_mode_btn;
            inc_q     <= tsc_inc_btn;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hr_en_q   <= 1'b0;
            sec_clr_q <= 1'b0;

            case (state_q)
                StRun: begin
                    rep_cnt_q <= '0;
                    per_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    blink_q   <= 1'b0;
                    if (mode_rise) begin
                        state_q   <= StSetMin;
                        sec_clr_q <= 1'b1;
                        blink_q   <= 1'b1;
                    end else if (tsc_tick) begin
                        sec_en_q <= 1'b1;
                        min_en_q <= tsc_sec_wrap;
                        hr_en_q  <= tsc_sec_wrap & tsc_min_wrap;
                    end
                end

                StSetMin, StSetHr: begin
                    if (mode_rise) begin
                        // Mode edge wins over any inc activity in the same cycle.
                        state_q   <= (state_q == StSetMin) ? StSetHr : StRun;
                        blink_q   <= (state_q == StSetMin);
                        rep_cnt_q <= '0;
                        per_cnt_q <= '0;
                        to_cnt_q  <= '0;
                    end else begin
                        if (!tsc_inc_btn || inc_rise) begin
                            rep_cnt_q <= '0;
                            per_cnt_q <= '0;
                        end else if (rep_cnt_q != RepDly) begin
                            rep_cnt_q <= rep_cnt_q + RW'(1);
                        end else begin
                            per_cnt_q <= (per_cnt_q == RepPerM1) ? '0 : per_cnt_q + PW'(1);
                        end

                        if (inc_rise || rep_fire) begin
                            if (state_q == StSetMin) begin
                                min_en_q <= 1'b1;
                            end else begin
                                hr_en_q <= 1'b1;
                            end
                        end

                        if (tsc_inc_btn) begin
                            to_cnt_q <= '0;
                        end
                        if (tsc_tick) begin
                            if (!tsc_inc_btn && (to_cnt_q == ToutM1)) begin
                                state_q  <= StRun;
                                to_cnt_q <= '0;
                                blink_q  <= 1'b0;
                            end else begin
                                if (!tsc_inc_btn) begin
                                    to_cnt_q <= to_cnt_q + TW'(1);
                                end
                                blink_q <= ~blink_q;
                            end
                        end
                    end
                end

                default: begin
                    state_q   <= StRun;
                    rep_cnt_q <= '0;
                    per_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    blink_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tsc_sec_en  = sec_en_q;
    assign tsc_min_en  = min_en_q;
    assign tsc_hr_en   = hr_en_q;
    assign tsc_sec_clr = sec_clr_q;
    assign tsc_state   = state_q;
    assign tsc_blink   = blink_q;

endmodule
